// File: rtl/keypad_scan_dbnc.sv
// keypad_scan_dbnc: 4x4 keypad column scanner with press/release debounce and no rollover.
// Define KEYPAD_SYNC_EN to pass row_n through a two-flop synchronizer.
module keypad_scan_dbnc #(
  parameter int SCAN_DIV    = 4,
  parameter int DBNC_CYCLES = 50
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int MAXC = SCAN_DIV > DBNC_CYCLES ? SCAN_DIV : DBNC_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] DWELL_TC = W'(SCAN_DIV - 1);
  localparam logic [W-1:0] DBNC_TC = W'(DBNC_CYCLES);
  // nibble {row,col} holds the hex legend of that key
  localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DBNC_PRESS, HELD, DBNC_REL} state_t;
  state_t state_q;
  logic [3:0] row_act;
  logic [1:0] col_q, col_d, row_q, row_enc;
  logic [W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic one_row, row_on;
`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  assign row_act = ~sync2_q;
`else
  assign row_act = ~row_n;
`endif
  always_comb begin
    col_d   = col_q + 2'd1;
    dwell_d = dwell_q == '1 ? dwell_q : dwell_q + W'(1);
    cnt_d   = cnt_q == '1 ? cnt_q : cnt_q + W'(1);
    one_row = row_act != 4'd0 && (row_act & (row_act - 4'd1)) == 4'd0;
    row_enc = row_act[3] ? 2'd3 : row_act[2] ? 2'd2 : row_act[1] ? 2'd1 : 2'd0;
    row_on  = row_act[row_q];
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      col_n     <= 4'b1110;
      row_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state_q)
        SCAN:
          if (dwell_q == DWELL_TC) begin
            dwell_q <= '0;
            if (one_row) begin
              row_q   <= row_enc;
              cnt_q   <= '0;
              state_q <= DBNC_PRESS;
            end else begin
              col_q <= col_d;
              col_n <= ~(4'b0001 << col_d);
            end
          end else dwell_q <= dwell_d;
        DBNC_PRESS:
          if (!row_on) begin
            state_q <= SCAN;
            col_q   <= col_d;
            col_n   <= ~(4'b0001 << col_d);
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == DBNC_TC) begin
              key_valid <= 1'b1;
              key_code  <= KMAP[{row_q, col_q, 2'b00} +: 4];
              key_held  <= 1'b1;
              state_q   <= HELD;
            end
          end
        HELD:
          if (!row_on) begin
            cnt_q   <= '0;
            state_q <= DBNC_REL;
          end
        DBNC_REL:
          if (row_on) state_q <= HELD;
          else begin
            cnt_q <= cnt_d;
            if (cnt_d == DBNC_TC) begin
              key_held <= 1'b0;
              state_q  <= SCAN;
              dwell_q  <= '0;
              col_q    <= col_d;
              col_n    <= ~(4'b0001 << col_d);
            end
          end
        default: state_q <= SCAN;
      endcase
    end
endmodule

// File: doc/keypad_scan_dbnc.md
KEYPAD_SCAN_DBNC -- requirements
Module: keypad_scan_dbnc

Interface
REQ-001 Parameter SCAN_DIV, default 4, clk cycles each column is driven before its rows are evaluated (legal 2..255).
REQ-002 Parameter DBNC_CYCLES, default 50, consecutive stable cycles needed to accept a press or a release (legal 2..1023).
REQ-003 clk  input  1  system clock (LSOSC domain).
REQ-004 nrst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 row_n  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 col_n  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  hex value of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse on each accepted press.
REQ-009 key_held  output  1  high while the accepted key is held, including during release debounce.

Function
REQ-010 row_act is ~row_n after the optional synchronizer (REQ-026/027); a row is active when its row_act bit is 1.
REQ-011 Key map (row,col -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-012 FSM states: SCAN, DBNC_PRESS, HELD, DBNC_REL.
REQ-013 SCAN: col_n drives column c; dwell counter runs 0..SCAN_DIV-1; at terminal count, exactly one active row -> latch row index and c, clear debounce counter, go DBNC_PRESS; else c advances 0->1->2->3->0.
REQ-014 Zero or two-plus active rows at terminal count: no latch, no output change; scan advances.
REQ-015 col_n frozen on the latched column in DBNC_PRESS, HELD and DBNC_REL.
REQ-016 DBNC_PRESS: counter increments each cycle the latched row is active; latched row inactive -> return to SCAN with c advanced, no pulse.
REQ-017 Counter reaching DBNC_CYCLES (DBNC_CYCLES cycles after entering DBNC_PRESS): key_valid high exactly one cycle; key_code updated same cycle; key_held set; go HELD.
REQ-018 HELD: latched row inactive -> clear counter, go DBNC_REL; other keys ignored (no rollover).
REQ-019 DBNC_REL: latched row active again -> HELD, no new pulse; DBNC_CYCLES consecutive inactive cycles -> key_held cleared, SCAN with c advanced.
REQ-020 key_code holds its value until the next key_valid.
REQ-021 Counters saturate, never wrap; width = ceil(log2(max(SCAN_DIV, DBNC_CYCLES)+1)).
REQ-022 Outputs registered; no combinational path from row_n to any output.

Reset
REQ-023 nrst low asynchronously forces: state SCAN, c=0, col_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0, all counters 0, synchronizer flops 1 (rows inactive).
REQ-024 Reset asserted mid-debounce or in HELD discards the pending key; no key_valid on reset release.
REQ-025 First column evaluation after reset release occurs SCAN_DIV cycles later.

Configuration
REQ-026 KEYPAD_SYNC_EN defined: each row_n bit passes a two-flop synchronizer; row_act lags row_n by 2 cycles.
REQ-027 KEYPAD_SYNC_EN undefined: row_act = ~row_n directly; all other timing unchanged.

Verification (SCAN_DIV=4, DBNC_CYCLES=8, KEYPAD_SYNC_EN defined)
REQ-028 nrst low mid-scan -> col_n=4'b1110, key_code=0, key_valid=0, key_held=0 immediately, without clk edge.
REQ-029 Key '5' (row1,col1) held 100 cycles -> exactly one key_valid, key_code=4'h5, key_held=1, col_n stays 4'b1101 until release + 8 cycles.
REQ-030 Row1 toggling every 3 cycles for 24 cycles on col1, then stable -> single key_valid, 8 cycles after the last edge + sync delay.
REQ-031 Keys '1' and '4' both held (col0, rows 0 and 1) -> no key_valid; col_n keeps rotating 1110->1101->1011->0111.
REQ-032 Hold 'A', press '0', release 'A' -> key_valid for 'A' only; after 8-cycle release debounce, scan finds '0', second pulse key_code=4'h0.
REQ-033 Release of '9' bouncing (3 inactive cycles, 1 active, then inactive) -> no second key_valid; key_held falls 8 cycles after final release.
